// File: rtl/spi_burst_mem.sv
// spi_burst_mem: SPI-slave burst access to on-chip word memory.
// Macro SPI_BURST_MEM_ERR_CNT_EN enables the aborted-frame counter.

module spi_burst_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AUTO_INC   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] err_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int HW    = ADDR_WIDTH + 1;
  localparam int CW    = $clog2(DATA_WIDTH + HW + 1);

  localparam logic [CW-1:0] HDR_LAST  = CW'(HW - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    WR,
    RD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic ss_s1, ss_s2, ss_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic mosi_s1, mosi_s2, mosi_h;

  logic ss_fall, ss_rise;
  logic sclk_rise, sclk_fall;
  logic rise_ok, frame_end;
  logic hdr_end, word_end;

  logic [CW-1:0]         cnt_q;
  logic [HW-2:0]         hdr_q;
  logic [HW-1:0]         hdr_nxt;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_adv;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] rx_nxt;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  reload_q;
  logic                  wr_pend_q;
  logic                  frame_done_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Two-flop synchronisers plus a history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_h    <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_h  <= 1'b0;
    end else begin
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_h    <= ss_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      mosi_h  <= mosi_s2;
    end
  end

  assign ss_fall   = ss_h & ~ss_s2;
  assign ss_rise   = ~ss_h & ss_s2;
  assign sclk_rise = ~sclk_h & sclk_s2;
  assign sclk_fall = sclk_h & ~sclk_s2;

  // mosi_h is the level one clk before the detected rise: settled data
  assign rise_ok   = sclk_rise & ~ss_rise;
  assign frame_end = ss_rise & (state_q != IDLE);
  assign hdr_end   = rise_ok & (cnt_q == HDR_LAST);
  assign word_end  = rise_ok & (cnt_q == WORD_LAST);

  assign hdr_nxt  = {hdr_q, mosi_h};
  assign hdr_addr = hdr_nxt[ADDR_WIDTH-1:0];
  assign rx_nxt   = {rx_q[DATA_WIDTH-2:0], mosi_h};

  assign addr_adv = (AUTO_INC != 0)
                  ? addr_q + ADDR_WIDTH'(1)
                  : addr_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: ss rise ends any frame, header picks the data phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (hdr_end) begin
          state_d = hdr_nxt[HW-1] ? WR : RD;
        end
      end
      default: begin
        if (frame_end) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Datapath: header/word shifting, address stepping, read reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      hdr_q        <= '0;
      addr_q       <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      reload_q     <= 1'b0;
      wr_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      if (wr_pend_q) begin
        addr_q <= addr_adv;
      end
      if (frame_end) begin
        frame_done_q <= 1'b1;
        cnt_q        <= '0;
        hdr_q        <= '0;
        tx_q         <= '0;
        reload_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ss_fall) begin
              cnt_q <= '0;
              hdr_q <= '0;
            end
          end
          HDR: begin
            if (hdr_end) begin
              cnt_q  <= '0;
              hdr_q  <= '0;
              addr_q <= hdr_addr;
              if (!hdr_nxt[HW-1]) begin
                tx_q     <= mem[hdr_addr];
                reload_q <= 1'b1;
              end
            end else if (rise_ok) begin
              cnt_q <= cnt_q + CW'(1);
              hdr_q <= hdr_nxt[HW-2:0];
            end
          end
          WR: begin
            if (rise_ok) begin
              rx_q <= rx_nxt;
              if (word_end) begin
                cnt_q     <= '0;
                wr_pend_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          default: begin
            if (word_end) begin
              cnt_q    <= '0;
              addr_q   <= addr_adv;
              reload_q <= 1'b1;
            end else if (rise_ok) begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (sclk_fall) begin
              if (reload_q) begin
                tx_q     <= mem[addr_q];
                reload_q <= 1'b0;
              end else begin
                tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        endcase
      end
    end
  end

  // Storage: completed write word lands one clk after its last bit
  always_ff @(posedge clk) begin
    if (wr_pend_q) begin
      mem[addr_q] <= rx_q;
    end
  end

  assign miso       = (state_q == RD) & tx_q[DATA_WIDTH-1];
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

`ifdef SPI_BURST_MEM_ERR_CNT_EN
  logic       abort;
  logic [7:0] err_q;

  assign abort = frame_end & (cnt_q != '0);

  // Saturating count of frames ended mid-header or mid-word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'd0;
    end else if (abort && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_burst_mem.sv
// tb_spi_burst_mem: random SPI frames vs a frame-level memory model.
// Drives an auto-increment and a fixed-address instance in parallel.

module tb_spi_burst_mem;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;

  logic       miso_1, busy_1, frame_done_1;
  logic [7:0] err_count_1;
  logic       miso_0, busy_0, frame_done_0;
  logic [7:0] err_count_0;

  spi_burst_mem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AUTO_INC(1)
  ) dut_inc (
    .clk(clk),
    .reset_n(reset_n),
    .ss(ss),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso_1),
    .busy(busy_1),
    .frame_done(frame_done_1),
    .err_count(err_count_1)
  );

  spi_burst_mem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AUTO_INC(0)
  ) dut_fix (
    .clk(clk),
    .reset_n(reset_n),
    .ss(ss),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso_0),
    .busy(busy_0),
    .frame_done(frame_done_0),
    .err_count(err_count_0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int fd1 = 0;
  int fd0 = 0;
  bit busy_seen = 0;

  logic [DW-1:0] m1 [16];
  logic [DW-1:0] m0 [16];
  int            exp_err = 0;

  logic [DW-1:0] wq [$];
  logic [DW-1:0] rq1 [$];
  logic [DW-1:0] rq0 [$];

  always @(negedge clk) begin
    if (frame_done_1) fd1++;
    if (frame_done_0) fd0++;
    if (busy_1 | busy_0) busy_seen = 1;
  end

  // Model: full words land at successive (inc) or same (fixed) address
  function automatic void model_write(input logic [3:0] a,
                                      input logic [DW-1:0] w[$]);
    logic [3:0] p;
    p = a;
    foreach (w[i]) begin
      m1[p] = w[i];
      m0[a] = w[i];
      p = p + 4'd1;
    end
  endfunction

  function automatic void model_abort();
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic logic [7:0] exp_err_count();
`ifdef SPI_BURST_MEM_ERR_CNT_EN
    return 8'(exp_err);
`else
    return 8'd0;
`endif
  endfunction

  task automatic spi_bit(input logic b,
                         output logic r1, output logic r0);
    mosi = b;
    repeat (HALF) @(negedge clk);
    r1 = miso_1;
    r0 = miso_0;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_open();
    ss = 1'b0;
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_close();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic send_bits(input int n);
    logic d1, d0;
    for (int i = 0; i < n; i++)
      spi_bit(1'($urandom_range(1, 0)), d1, d0);
  endtask

  task automatic send_header(input logic rw, input logic [3:0] a);
    logic [4:0] h;
    logic d1, d0;
    h = {rw, a};
    for (int i = 4; i >= 0; i--) spi_bit(h[i], d1, d0);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    logic d1, d0;
    for (int i = DW - 1; i >= 0; i--) spi_bit(w[i], d1, d0);
  endtask

  task automatic write_frame(input logic [3:0] a,
                             input logic [DW-1:0] w[$]);
    spi_open();
    send_header(1'b1, a);
    foreach (w[i]) send_word(w[i]);
    spi_close();
  endtask

  task automatic read_frame(input logic [3:0] a, input int n);
    logic [DW-1:0] r1, r0;
    logic b1, b0;
    rq1.delete();
    rq0.delete();
    spi_open();
    send_header(1'b0, a);
    for (int k = 0; k < n; k++) begin
      r1 = '0;
      r0 = '0;
      for (int i = 0; i < DW; i++) begin
        spi_bit(1'($urandom_range(1, 0)), b1, b0);
        r1 = {r1[DW-2:0], b1};
        r0 = {r0[DW-2:0], b0};
      end
      rq1.push_back(r1);
      rq0.push_back(r0);
    end
    spi_close();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_1, miso_1, frame_done_1, err_count_1} !== 11'd0) begin
      fails++;
      $display("FAIL reset_inc: got %b expected 0",
               {busy_1, miso_1, frame_done_1, err_count_1});
    end
    checks++;
    if ({busy_0, miso_0, frame_done_0, err_count_0} !== 11'd0) begin
      fails++;
      $display("FAIL reset_fix: got %b expected 0",
               {busy_0, miso_0, frame_done_0, err_count_0});
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy_1, busy_0, miso_1, miso_0} !== 4'd0) begin
      fails++;
      $display("FAIL reset_release: got %b expected 0",
               {busy_1, busy_0, miso_1, miso_0});
    end
  endtask

  task automatic test_fill();
    int f1, f0;
    f1 = fd1;
    f0 = fd0;
    for (int a = 0; a < 16; a++) begin
      wq = {DW'($urandom)};
      write_frame(4'(a), wq);
      model_write(4'(a), wq);
    end
    checks++;
    if (fd1 - f1 != 16 || fd0 - f0 != 16) begin
      fails++;
      $display("FAIL fill_frame_done: got %0d/%0d expected 16",
               fd1 - f1, fd0 - f0);
    end
    for (int a = 0; a < 16; a++) begin
      read_frame(4'(a), 1);
      checks++;
      if (rq1[0] !== m1[a]) begin
        fails++;
        $display("FAIL fill_inc[%0d]: got %h expected %h",
                 a, rq1[0], m1[a]);
      end
      checks++;
      if (rq0[0] !== m0[a]) begin
        fails++;
        $display("FAIL fill_fix[%0d]: got %h expected %h",
                 a, rq0[0], m0[a]);
      end
    end
  endtask

  task automatic test_write_read();
    int f1;
    f1 = fd1;
    wq = {32'hDEADBEEF};
    write_frame(4'd3, wq);
    model_write(4'd3, wq);
    checks++;
    if (fd1 - f1 != 1 || busy_1 !== 1'b0) begin
      fails++;
      $display("FAIL wr_frame_done: got %0d busy %b expected 1 busy 0",
               fd1 - f1, busy_1);
    end
    read_frame(4'd3, 1);
    checks++;
    if (rq1[0] !== m1[3]) begin
      fails++;
      $display("FAIL write_read: got %h expected %h", rq1[0], m1[3]);
    end
    checks++;
    if (fd1 - f1 != 2) begin
      fails++;
      $display("FAIL rd_frame_done: got %0d expected 2", fd1 - f1);
    end
  endtask

  task automatic test_burst_wrap();
    logic [3:0] p;
    wq = {32'h11111111, 32'h22222222, 32'h33333333};
    write_frame(4'd14, wq);
    model_write(4'd14, wq);
    read_frame(4'd14, 3);
    for (int i = 0; i < 3; i++) begin
      p = 4'(14 + i);
      checks++;
      if (rq1[i] !== m1[p]) begin
        fails++;
        $display("FAIL wrap_inc[%0d]: got %h expected %h",
                 i, rq1[i], m1[p]);
      end
      checks++;
      if (rq0[i] !== m0[14]) begin
        fails++;
        $display("FAIL wrap_fix[%0d]: got %h expected %h",
                 i, rq0[i], m0[14]);
      end
    end
  endtask

  task automatic test_fixed();
    logic [3:0] p;
    wq = {32'hAAAAAAAA, 32'h55555555};
    write_frame(4'd5, wq);
    model_write(4'd5, wq);
    read_frame(4'd5, 2);
    for (int i = 0; i < 2; i++) begin
      p = 4'(5 + i);
      checks++;
      if (rq0[i] !== m0[5]) begin
        fails++;
        $display("FAIL fixed_fix[%0d]: got %h expected %h",
                 i, rq0[i], m0[5]);
      end
      checks++;
      if (rq1[i] !== m1[p]) begin
        fails++;
        $display("FAIL fixed_inc[%0d]: got %h expected %h",
                 i, rq1[i], m1[p]);
      end
    end
  endtask

  task automatic test_abort();
    int f1;
    f1 = fd1;
    spi_open();
    send_header(1'b1, 4'd2);
    send_bits(12);
    spi_close();
    model_abort();
    checks++;
    if (fd1 - f1 != 1 || busy_1 !== 1'b0 || busy_0 !== 1'b0) begin
      fails++;
      $display("FAIL abort_end: got fd %0d busy %b%b expected 1 00",
               fd1 - f1, busy_1, busy_0);
    end
    checks++;
    if (err_count_1 !== exp_err_count() ||
        err_count_0 !== exp_err_count()) begin
      fails++;
      $display("FAIL abort_err: got %0d/%0d expected %0d",
               err_count_1, err_count_0, exp_err_count());
    end
    spi_open();
    send_bits(3);
    spi_close();
    model_abort();
    spi_open();
    spi_close();
    checks++;
    if (err_count_1 !== exp_err_count()) begin
      fails++;
      $display("FAIL abort_hdr_err: got %0d expected %0d",
               err_count_1, exp_err_count());
    end
    read_frame(4'd2, 1);
    checks++;
    if (rq1[0] !== m1[2] || rq0[0] !== m0[2]) begin
      fails++;
      $display("FAIL abort_mem: got %h/%h expected %h/%h",
               rq1[0], rq0[0], m1[2], m0[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w1;
    w1 = DW'($urandom);
    spi_open();
    send_header(1'b1, 4'd0);
    send_word(w1);
    send_bits(16);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_1, busy_0, miso_1, miso_0} !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid: got %b expected 0",
               {busy_1, busy_0, miso_1, miso_0});
    end
    ss = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    wq = {w1};
    model_write(4'd0, wq);
    exp_err = 0;
    checks++;
    if (err_count_1 !== 8'd0 || busy_1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_err: got %0d busy %b expected 0 0",
               err_count_1, busy_1);
    end
    read_frame(4'd0, 2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rq1[i] !== m1[i]) begin
        fails++;
        $display("FAIL reset_mid_mem[%0d]: got %h expected %h",
                 i, rq1[i], m1[i]);
      end
    end
    wq = {DW'($urandom)};
    write_frame(4'd9, wq);
    model_write(4'd9, wq);
    read_frame(4'd9, 1);
    checks++;
    if (rq1[0] !== m1[9] || rq0[0] !== m0[9]) begin
      fails++;
      $display("FAIL reset_mid_next: got %h/%h expected %h/%h",
               rq1[0], rq0[0], m1[9], m0[9]);
    end
  endtask

  task automatic test_stray_sclk();
    int f1;
    f1 = fd1;
    ss = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom_range(1, 0));
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      checks++;
      if (miso_1 !== 1'b0 || miso_0 !== 1'b0) begin
        fails++;
        $display("FAIL stray_miso[%0d]: got %b%b expected 00",
                 i, miso_1, miso_0);
      end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy_seen || fd1 != f1) begin
      fails++;
      $display("FAIL stray_state: got busy %0d fd %0d expected 0 0",
               busy_seen, fd1 - f1);
    end
    for (int a = 0; a < 16; a += 5) begin
      read_frame(4'(a), 1);
      checks++;
      if (rq1[0] !== m1[a] || rq0[0] !== m0[a]) begin
        fails++;
        $display("FAIL stray_mem[%0d]: got %h/%h expected %h/%h",
                 a, rq1[0], rq0[0], m1[a], m0[a]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] a, p;
    int n;
    for (int k = 0; k < 10; k++) begin
      a = 4'($urandom);
      n = $urandom_range(3, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
      write_frame(a, wq);
      model_write(a, wq);
      a = 4'($urandom);
      n = $urandom_range(3, 1);
      read_frame(a, n);
      for (int i = 0; i < n; i++) begin
        p = 4'(a + 4'(i));
        checks++;
        if (rq1[i] !== m1[p] || rq0[i] !== m0[a]) begin
          fails++;
          $display("FAIL rand[%0d.%0d]: got %h/%h expected %h/%h",
                   k, i, rq1[i], rq0[i], m1[p], m0[a]);
        end
      end
    end
  endtask

  task automatic test_err_saturate();
    for (int k = 0; k < 258; k++) begin
      spi_open();
      send_bits(1);
      spi_close();
      model_abort();
    end
    checks++;
    if (err_count_1 !== exp_err_count() ||
        err_count_0 !== exp_err_count()) begin
      fails++;
      $display("FAIL err_saturate: got %0d/%0d expected %0d",
               err_count_1, err_count_0, exp_err_count());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_burst_wrap();
    test_fixed();
    test_abort();
    test_reset_mid();
    test_stray_sclk();
    test_random();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
